// File: rtl/pio_frac_clock_divider.sv
// Multi-channel fractional clock-enable generator: each channel emits a one-cycle
// tick at an average rate of clock / (D + div_frac/2^FRAC_W).
module pio_frac_clock_divider #(
  parameter int NUM_CH = 4,
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        enable_i,
  input  logic [NUM_CH-1:0]        restart_i,
  input  logic [NUM_CH*INT_W-1:0]  div_int_i,
  input  logic [NUM_CH*FRAC_W-1:0] div_frac_i,
  output logic [NUM_CH-1:0]        tick_o
);

  localparam logic [INT_W-1:0] INT_ONE = {{(INT_W-1){1'b0}}, 1'b1};
  localparam logic [INT_W:0]   CNT_ONE = {{INT_W{1'b0}}, 1'b1};

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [INT_W:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              tick_q, tick_d;
    logic [INT_W-1:0]  div_int_ch;
    logic [INT_W-1:0]  div_m1;
    logic [FRAC_W-1:0] div_frac_ch;
    logic [FRAC_W:0]   frac_sum;
    logic [INT_W:0]    reload;

    assign div_int_ch  = div_int_i[gi*INT_W +: INT_W];
    assign div_frac_ch = div_frac_i[gi*FRAC_W +: FRAC_W];
    assign frac_sum    = {1'b0, acc_q} + {1'b0, div_frac_ch};
    // div_int==0 wraps to all-ones here, i.e. D-1 = 2^INT_W - 1
    assign div_m1      = div_int_ch - INT_ONE;
    assign reload      = {1'b0, div_m1} + {{INT_W{1'b0}}, frac_sum[FRAC_W]};

    always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      tick_d = 1'b0;
      if (restart_i[gi]) begin
        cnt_d = '0;
        acc_d = '0;
      end else if (enable_i[gi]) begin
        if (cnt_q == '0) begin
          tick_d = 1'b1;
          cnt_d  = reload;
          acc_d  = frac_sum[FRAC_W-1:0];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_q  <= '0;
        acc_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        acc_q  <= acc_d;
        tick_q <= tick_d;
      end
    end

    assign tick_o[gi] = tick_q;
  end

endmodule
